conv_window_scheduler: RTL

- Sequences one convUnit instance across a full input feature map. Walks every output position in raster order.
- For each position it presents the window origin to the window-fetch logic, then runs convUnit by holding conv_en. It waits for cu_out_valid and writes the float16 result to the output feature-map buffer at a linear address.
- Sits between the layer controller (start/done) and the convUnit + window buffer pair.

---
 rtl/conv_window_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: raster-order sequencer driving one convUnit across an input feature map
module conv_window_scheduler #(
  parameter int data_width = 16,
  parameter int image_length = 5,
  parameter int image_width = 5,
  parameter int weight_length = 3,
  parameter int weight_width = 3,
  parameter int stride = 1,
  parameter int max_wait = 64,
  localparam int out_length = (image_length - weight_length) / stride + 1,
  localparam int out_width = (image_width - weight_width) / stride + 1,
  localparam int n_out = out_length * out_width,
  localparam int rw = image_length > 1 ? $clog2(image_length) : 1,
  localparam int cw = image_width > 1 ? $clog2(image_width) : 1,
  localparam int aw = n_out > 1 ? $clog2(n_out) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  win_req,
  output logic [rw-1:0]         win_row,
  output logic [cw-1:0]         win_col,
  output logic                  conv_en,
  input  logic                  cu_out_valid,
  input  logic [data_width-1:0] cu_result,
  output logic                  out_valid,
  output logic [aw-1:0]         out_addr,
  output logic [data_width-1:0] out_data
);
  localparam int orw = out_length > 1 ? $clog2(out_length) : 1;
  localparam int ocw = out_width > 1 ? $clog2(out_width) : 1;
  localparam int ww = max_wait > 1 ? $clog2(max_wait) : 1;
  localparam logic [rw-1:0] row_step = rw'(stride);
  localparam logic [cw-1:0] col_step = cw'(stride);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, DONE} state_t;
  state_t state;
  logic [orw-1:0] out_row;
  logic [ocw-1:0] out_col;
  logic [aw-1:0] addr_cnt;
  logic [ww-1:0] wait_cnt;
  logic row_end, layer_end;
  assign row_end = out_col == ocw'(out_width - 1);
  assign layer_end = row_end && out_row == orw'(out_length - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      win_req <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      conv_en <= 1'b0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
      addr_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      win_req <= 1'b0;
      out_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          out_row <= '0;
          out_col <= '0;
          addr_cnt <= '0;
          wait_cnt <= '0;
          if (start) begin
            state <= LOAD;
            busy <= 1'b1;
            timeout <= 1'b0;
            win_req <= 1'b1;
            win_row <= '0;
            win_col <= '0;
          end
        end
        LOAD: begin
          state <= RUN;
          conv_en <= 1'b1;
        end
        RUN: begin
          if (cu_out_valid) begin
            state <= WRITE;
            conv_en <= 1'b0;
            out_valid <= 1'b1;
            out_addr <= addr_cnt;
            out_data <= cu_result;
          end else if (wait_cnt == ww'(max_wait - 1)) begin
            state <= DONE;
            conv_en <= 1'b0;
            timeout <= 1'b1;
            done <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + ww'(1);
          end
        end
        WRITE: begin
          if (layer_end) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= LOAD;
            win_req <= 1'b1;
            out_col <= row_end ? '0 : out_col + ocw'(1);
            out_row <= row_end ? out_row + orw'(1) : out_row;
            win_col <= row_end ? '0 : win_col + col_step;
            win_row <= row_end ? win_row + row_step : win_row;
            addr_cnt <= addr_cnt + aw'(1);
            wait_cnt <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
